// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq
// Description : Instruction fetch sequencer. It walks the program counter
//               through a synchronous program ROM (one cycle read latency) and
//               assembles each instruction into instr0, plus instr1 for the
//               two-word opcodes. It holds every instruction for one EXEC
//               cycle, applies branch redirects sampled in EXEC, and halts on
//               the end opcode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1     rising-edge clock
//   reset         in   1     synchronous active-high reset
//   start         in   1     start pulse, honoured only while halted
//   start_addr    in   PC_W  PC loaded when start is accepted
//   pmem_addr     out  PC_W  program memory address (always equals pc)
//   pmem_data     in   32    ROM read data, valid one cycle after pmem_addr
//   jmp_valid     in   1     branch taken, honoured only in EXEC
//   jmp_target    in   PC_W  branch destination
//   instr0        out  32    first instruction word (registered)
//   instr1        out  32    second instruction word, 0 for one-word ops
//   current_state out  4     sequencer state code
//   pc            out  PC_W  program counter
//   halted        out  1     high while in HLT
// ============================================================================
module instr_fetch_seq #(
  parameter int         PC_W      = 16,
  parameter logic [7:0] OP_LIMM32 = 8'h02,
  parameter logic [7:0] OP_LBSET  = 8'h01,
  parameter logic [7:0] OP_END    = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  output logic [PC_W-1:0] pmem_addr,
  input  logic [31:0]     pmem_data,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  output logic [31:0]     instr0,
  output logic [31:0]     instr1,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  // State encoding is visible to the datapath, so codes are fixed.
  typedef enum logic [3:0] {
    S_HLT      = 4'd0,
    S_FETCH0   = 4'd1,
    S_FETCH0_L = 4'd2,
    S_FETCH1   = 4'd3,
    S_FETCH1_L = 4'd4,
    S_EXEC     = 4'd5
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr0;
  logic [31:0]     r_instr1;
  logic            r_halted;

  logic [7:0]      w_rom_opcode;   // opcode of the word arriving from the ROM
  logic [7:0]      w_cur_opcode;   // opcode of the instruction being executed
  logic            w_two_word;
  logic [PC_W-1:0] w_pc_inc;

  assign w_rom_opcode = pmem_data[31:24];
  assign w_cur_opcode = r_instr0[31:24];
  assign w_two_word   = (w_rom_opcode == OP_LIMM32) || (w_rom_opcode == OP_LBSET);
  // Natural modulo-2^PC_W wrap, also between the two words of an instruction.
  assign w_pc_inc     = r_pc + PC_W'(1);

  // Single sequencer process; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_HLT;
      r_pc     <= '0;
      r_instr0 <= '0;
      r_instr1 <= '0;
      r_halted <= 1'b1;
    end else begin
      case (r_state)
        S_HLT: begin
          if (start) begin
            r_pc     <= start_addr;
            r_halted <= 1'b0;
            r_state  <= S_FETCH0;
          end else begin
            r_halted <= 1'b1;
          end
        end

        // Address is already on pmem_addr; wait for the ROM read.
        S_FETCH0: begin
          r_state <= S_FETCH0_L;
        end

        S_FETCH0_L: begin
          r_instr0 <= pmem_data;
          r_instr1 <= '0;
          r_pc     <= w_pc_inc;
          r_state  <= w_two_word ? S_FETCH1 : S_EXEC;
        end

        S_FETCH1: begin
          r_state <= S_FETCH1_L;
        end

        S_FETCH1_L: begin
          r_instr1 <= pmem_data;
          r_pc     <= w_pc_inc;
          r_state  <= S_EXEC;
        end

        // END outranks a branch so a halting program never redirects.
        S_EXEC: begin
          if (w_cur_opcode == OP_END) begin
            r_halted <= 1'b1;
            r_state  <= S_HLT;
          end else if (jmp_valid) begin
            r_pc    <= jmp_target;
            r_state <= S_FETCH0;
          end else begin
            r_state <= S_FETCH0;
          end
        end

        // Unused codes recover to HLT.
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HLT;
        end
      endcase
    end
  end

  assign pmem_addr     = r_pc;
  assign pc            = r_pc;
  assign instr0        = r_instr0;
  assign instr1        = r_instr1;
  assign current_state = r_state;
  assign halted        = r_halted;

endmodule
`default_nettype wire
